// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: FSM states, opcode/funct
// values, ALUctr codes and datapath select codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXE_R   = 4'd2,
        S_WB_R    = 4'd3,
        S_EXE_I   = 4'd4,
        S_WB_I    = 4'd5,
        S_MEM_ADR = 4'd6,
        S_MEM_RD  = 4'd7,
        S_WB_LW   = 4'd8,
        S_MEM_WR  = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// R-type funct decoder: ALU operation plus a legality flag.
// Macro MC_CTRL_SLTU_EN adds sltu as a legal funct.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] aluctr,
    output logic       legal
);

    always_comb begin
        aluctr = ALU_ADD;
        legal  = 1'b0;
        case (funct)
            FN_ADDU: begin
                aluctr = ALU_ADD;
                legal  = 1'b1;
            end
            FN_SUBU: begin
                aluctr = ALU_SUB;
                legal  = 1'b1;
            end
`ifdef MC_CTRL_SLTU_EN
            FN_SLTU: begin
                aluctr = ALU_SLTU;
                legal  = 1'b1;
            end
`endif
            default: begin
                aluctr = ALU_ADD;
                legal  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset CPU. Optional sltu support via the
// MC_CTRL_SLTU_EN macro (handled in mc_alu_dec).
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_rdy,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemRd,
    output logic       MemWr,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ExtOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUctr,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] dbg_state
);

    state_t     state;
    logic [2:0] r_aluctr;
    logic       r_legal;

    mc_alu_dec u_alu_dec (
        .funct  (funct),
        .aluctr (r_aluctr),
        .legal  (r_legal)
    );

    assign dbg_state = state;

    // Memory handshake: MemRd/MemWr is held constant while the FSM sits in a request
    // state; the access completes on the first cycle mem_rdy=1, and mem_rdy is ignored
    // in every other state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:   state <= mem_rdy ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (op)
                        OP_RTYPE: state <= r_legal ? S_EXE_R : S_FETCH;
                        OP_ORI:   state <= S_EXE_I;
                        OP_LW:    state <= S_MEM_ADR;
                        OP_SW:    state <= S_MEM_ADR;
                        OP_BEQ:   state <= S_BRANCH;
                        OP_J:     state <= S_JUMP;
                        default:  state <= S_FETCH;
                    endcase
                end
                S_EXE_R:   state <= S_WB_R;
                S_EXE_I:   state <= S_WB_I;
                S_MEM_ADR: state <= (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:  state <= mem_rdy ? S_WB_LW : S_MEM_RD;
                S_MEM_WR:  state <= mem_rdy ? S_FETCH : S_MEM_WR;
                default:   state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        PCWr       = 1'b0;
        IRWr       = 1'b0;
        RegWr      = 1'b0;
        MemRd      = 1'b0;
        MemWr      = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ExtOp      = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RT;
        PCSrc      = PCSRC_ALU;
        ALUctr     = ALU_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                MemRd   = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWr    = mem_rdy;
                PCWr    = mem_rdy;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH2;
                ExtOp   = 1'b1;
                case (op)
                    OP_RTYPE:                        illegal = ~r_legal;
                    OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J: illegal = 1'b0;
                    default:                         illegal = 1'b1;
                endcase
            end
            S_EXE_R: begin
                ALUSrcA = 1'b1;
                ALUctr  = r_aluctr;
            end
            S_WB_R: begin
                RegWr      = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_EXE_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUctr  = ALU_OR;
            end
            S_WB_I, S_WB_LW: begin
                RegWr      = 1'b1;
                MemtoReg   = (state == S_WB_LW);
                instr_done = 1'b1;
            end
            S_MEM_ADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ExtOp   = 1'b1;
            end
            S_MEM_RD: MemRd = 1'b1;
            S_MEM_WR: begin
                MemWr      = 1'b1;
                instr_done = mem_rdy;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUctr     = ALU_SUB;
                PCSrc      = PCSRC_ALUOUT;
                PCWr       = zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCSrc      = PCSRC_JUMP;
                PCWr       = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
                PCWr = 1'b0;
            end
        endcase
        // Reset forces every control line low so an aborted instruction writes nothing.
        if (reset) begin
            PCWr       = 1'b0;
            IRWr       = 1'b0;
            RegWr      = 1'b0;
            MemRd      = 1'b0;
            MemWr      = 1'b0;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            ExtOp      = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = SRCB_RT;
            PCSrc      = PCSRC_ALU;
            ALUctr     = ALU_ADD;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction expected control traces are built
// from the instruction rules and compared cycle by cycle.
module tb_mc_ctrl;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_SLTU = 6'b101011;
`ifdef MC_CTRL_SLTU_EN
    localparam bit SLTU_EN = 1'b1;
`else
    localparam bit SLTU_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pcwr;
        logic       irwr;
        logic       regwr;
        logic       memrd;
        logic       memwr;
        logic       regdst;
        logic       memtoreg;
        logic       extop;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [2:0] aluctr;
        logic       done;
        logic       illegal;
    } ctl_t;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [5:0] op, funct;
    logic       zero, mem_rdy;
    logic       PCWr, IRWr, RegWr, MemRd, MemWr, RegDst, MemtoReg, ExtOp, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUctr;
    logic       instr_done, illegal;
    logic [3:0] dbg_state;

    mc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_rdy    (mem_rdy),
        .PCWr       (PCWr),
        .IRWr       (IRWr),
        .RegWr      (RegWr),
        .MemRd      (MemRd),
        .MemWr      (MemWr),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ExtOp      (ExtOp),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUctr     (ALUctr),
        .instr_done (instr_done),
        .illegal    (illegal),
        .dbg_state  (dbg_state)
    );

    // scoreboard: expected control per cycle plus the {mem_rdy, zero} to drive that cycle
    logic [$bits(ctl_t)-1:0] exp_q[$];
    logic [1:0]              stim_q[$];
    int checks = 0;
    int errors = 0;

    function automatic ctl_t observed();
        ctl_t o;
        o.pcwr = PCWr;        o.irwr = IRWr;         o.regwr = RegWr;
        o.memrd = MemRd;      o.memwr = MemWr;       o.regdst = RegDst;
        o.memtoreg = MemtoReg; o.extop = ExtOp;      o.srca = ALUSrcA;
        o.srcb = ALUSrcB;     o.pcsrc = PCSrc;       o.aluctr = ALUctr;
        o.done = instr_done;  o.illegal = illegal;
        return o;
    endfunction

    function automatic bit supported(input logic [5:0] o, input logic [5:0] f);
        if (o == OP_R)
            return (f == FN_ADDU) || (f == FN_SUBU) || (SLTU_EN && f == FN_SLTU);
        return (o == OP_ORI) || (o == OP_LW) || (o == OP_SW) || (o == OP_BEQ) || (o == OP_J);
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string tag, input ctl_t obs, input ctl_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input ctl_t c, input logic rdy, input logic z);
        exp_q.push_back(c);
        stim_q.push_back({rdy, z});
    endtask

    // Reference model: the control trace one instruction should produce, given how many
    // cycles memory stalls in fetch and in the data access, and the branch zero flag.
    task automatic model_instr(input logic [5:0] o, input logic [5:0] f,
                               input int fs, input int ms, input logic zb);
        ctl_t c;
        for (int i = 0; i < fs; i++) begin
            c = '0; c.memrd = 1'b1; c.srcb = 2'b01;
            push(c, 1'b0, rbit());
        end
        c = '0; c.memrd = 1'b1; c.srcb = 2'b01; c.irwr = 1'b1; c.pcwr = 1'b1;
        push(c, 1'b1, rbit());
        c = '0; c.srcb = 2'b11; c.extop = 1'b1; c.illegal = !supported(o, f);
        push(c, rbit(), rbit());
        if (!supported(o, f)) return;
        case (o)
            OP_R: begin
                c = '0; c.srca = 1'b1;
                c.aluctr = (f == FN_SUBU) ? 3'b100 : (f == FN_SLTU) ? 3'b110 : 3'b000;
                push(c, rbit(), rbit());
                c = '0; c.regwr = 1'b1; c.regdst = 1'b1; c.done = 1'b1;
                push(c, rbit(), rbit());
            end
            OP_ORI: begin
                c = '0; c.srca = 1'b1; c.srcb = 2'b10; c.aluctr = 3'b010;
                push(c, rbit(), rbit());
                c = '0; c.regwr = 1'b1; c.done = 1'b1;
                push(c, rbit(), rbit());
            end
            OP_LW, OP_SW: begin
                c = '0; c.srca = 1'b1; c.srcb = 2'b10; c.extop = 1'b1;
                push(c, rbit(), rbit());
                for (int i = 0; i < ms; i++) begin
                    c = '0; c.memrd = (o == OP_LW); c.memwr = (o == OP_SW);
                    push(c, 1'b0, rbit());
                end
                c = '0; c.memrd = (o == OP_LW); c.memwr = (o == OP_SW); c.done = (o == OP_SW);
                push(c, 1'b1, rbit());
                if (o == OP_LW) begin
                    c = '0; c.regwr = 1'b1; c.memtoreg = 1'b1; c.done = 1'b1;
                    push(c, rbit(), rbit());
                end
            end
            OP_BEQ: begin
                c = '0; c.srca = 1'b1; c.aluctr = 3'b100; c.pcsrc = 2'b01;
                c.pcwr = zb; c.done = 1'b1;
                push(c, rbit(), zb);
            end
            default: begin
                c = '0; c.pcsrc = 2'b10; c.pcwr = 1'b1; c.done = 1'b1;
                push(c, rbit(), rbit());
            end
        endcase
    endtask

    // driver: replays the queued stimulus with op/funct held, checking each cycle
    task automatic run_queue(input string tag, input logic [5:0] o, input logic [5:0] f);
        logic [1:0] s;
        ctl_t       e;
        int         n = 0;
        op = o;
        funct = f;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            mem_rdy = s[1];
            zero    = s[0];
            @(negedge clk);
            n++;
            check($sformatf("%s_c%0d", tag, n), observed(), e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                            input int fs, input int ms, input logic zb);
        model_instr(o, f, fs, ms, zb);
        run_queue(tag, o, f);
    endtask

    initial begin
        logic [5:0] o, f;
        int         k;
        reset   = 1'b1;
        op      = 6'($urandom);
        funct   = 6'($urandom);
        zero    = 1'b1;
        mem_rdy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", observed(), '0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        do_instr("addu", OP_R, FN_ADDU, 0, 0, 1'b0);
        do_instr("lw_stall2", OP_LW, 6'($urandom), 0, 2, 1'b0);
        do_instr("beq_taken", OP_BEQ, 6'($urandom), 0, 0, 1'b1);
        do_instr("beq_not_taken", OP_BEQ, 6'($urandom), 0, 0, 1'b0);
        do_instr("illegal_op", 6'b111111, 6'($urandom), 0, 0, 1'b0);
        do_instr("sltu", OP_R, FN_SLTU, 0, 0, 1'b0);
        do_instr("subu_fstall", OP_R, FN_SUBU, 2, 0, 1'b0);
        do_instr("ori", OP_ORI, 6'($urandom), 0, 0, 1'b0);
        do_instr("sw_stall", OP_SW, 6'($urandom), 1, 2, 1'b0);
        do_instr("jump", OP_J, 6'($urandom), 0, 0, 1'b0);
        do_instr("bad_funct", OP_R, 6'b000000, 0, 0, 1'b0);

        // reset while a store is waiting on memory: keep fetch..MEM_WR plus one stall
        model_instr(OP_SW, 6'd0, 0, 3, 1'b0);
        repeat (3) begin
            void'(exp_q.pop_back());
            void'(stim_q.pop_back());
        end
        run_queue("sw_pre_reset", OP_SW, 6'd0);
        reset   = 1'b1;
        mem_rdy = 1'b0;
        @(negedge clk);
        check("reset_in_memwr", observed(), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_instr("after_reset", OP_R, FN_ADDU, 1, 0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 8);
            f = 6'($urandom);
            case (k)
                0: begin o = OP_R; f = FN_ADDU; end
                1: begin o = OP_R; f = FN_SUBU; end
                2: begin o = OP_R; f = ($urandom_range(0, 1) == 1) ? FN_SLTU : f; end
                3: o = OP_ORI;
                4: o = OP_LW;
                5: o = OP_SW;
                6: o = OP_BEQ;
                7: o = OP_J;
                default: o = 6'($urandom);
            endcase
            do_instr($sformatf("rand%0d", i), o, f,
                     $urandom_range(0, 2), $urandom_range(0, 2), rbit());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
